// File: rtl/ahb_timer_pkg.sv
// Shared constants and types for the AHB-Lite timer peripheral.
package ahb_timer_pkg;

  // Register word offsets (HADDR[4:2])
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_LOAD     = 3'd1;
  localparam logic [2:0] OFF_VALUE    = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Bus response sequencer states
  typedef enum logic [1:0] {
    OKAY = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } resp_state_t;

  // Address-phase information carried into the data phase
  typedef struct packed {
    logic       valid;
    logic       write;
    logic [2:0] off;
  } dphase_t;

endpackage

// File: rtl/ahb_timer_if.sv
// AHB-Lite slave-side signal bundle for the timer.
//   slave modport : hsel/hready/htrans/hsize/hwrite/haddr/hwdata in,
//                   hreadyout/hresp/hrdata out
//   master modport: the mirror image
interface ahb_timer_if;
  logic        hsel;
  logic        hready;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport slave (
    input  hsel, hready, htrans, hsize, hwrite, haddr, hwdata,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hsel, hready, htrans, hsize, hwrite, haddr, hwdata,
    input  hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_timer_prescaler.sv
// Prescaler: emits a one-cycle tick every prescale+1 cycles while enabled.
//   clk, rst  : clock, async active-high reset
//   en        : counting enable (counter held at 0 when low)
//   clr       : restart the count (prescale register being written)
//   prescale  : divide value minus one
//   tick_c    : combinational tick for the current cycle
module timer_prescaler #(
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick_c
);

  logic [PRE_W-1:0] cnt_q;

  assign tick_c = en & (cnt_q == prescale);

  // Cycle counter, wraps on each tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || clr || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PRE_W'(1);
    end
  end

endmodule

// File: rtl/ahb_timer.sv
// AHB-Lite down-counting timer with reload, one-shot/periodic mode and
// level interrupt. Zero-wait register access; two-cycle ERROR response for
// unmapped offsets or non-word transfers.
//   clk, rst  : clock, async active-high reset
//   bus       : ahb_timer_if.slave (AHB-Lite slave signals)
//   timer_irq : STATUS.IRQ & CTRL.IRQEN
// Optional: define AHB_TIMER_PRESCALE_EN to add the PRESCALE register (0x10).
module ahb_timer
  import ahb_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PRE_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  ahb_timer_if.slave bus,
  output logic       timer_irq
);

  if (CNT_W < 1 || CNT_W > 32 || PRE_W < 1 || PRE_W > 32) begin : g_bad_param
    $error("ahb_timer: CNT_W and PRE_W must lie in 1..32");
  end

  resp_state_t      state_q, state_d;
  logic             hreadyout_q, hreadyout_d;
  logic             hresp_q, hresp_d;
  dphase_t          dp_q, dp_d;
  logic             ap_valid_c, ap_err_c, off_mapped_c;
  logic             ctrl_en_q, ctrl_en_d;
  logic             ctrl_irqen_q, ctrl_irqen_d;
  logic             ctrl_oneshot_q, ctrl_oneshot_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] value_q, value_d;
  logic             irq_q, irq_d;
  logic             tick_c, zero_evt_c;
  logic             wr_ctrl_c, wr_load_c, wr_value_c, wr_status_c;
  logic [31:0]      rdata_c;
  logic             unused_c;

  // Address-phase decode
  assign ap_valid_c = bus.hsel & bus.hready & bus.htrans[1];

  always_comb begin
    off_mapped_c = 1'b0;
    case (bus.haddr[4:2])
      OFF_CTRL, OFF_LOAD, OFF_VALUE, OFF_STATUS: off_mapped_c = 1'b1;
`ifdef AHB_TIMER_PRESCALE_EN
      OFF_PRESCALE: off_mapped_c = 1'b1;
`endif
      default: off_mapped_c = 1'b0;
    endcase
  end

  assign ap_err_c = ap_valid_c & (~off_mapped_c | (bus.hsize != HSIZE_WORD));

  // Errored transfers never reach the data phase, so registers stay untouched
  always_comb begin
    dp_d.valid = ap_valid_c & ~ap_err_c;
    dp_d.write = bus.hwrite;
    dp_d.off   = bus.haddr[4:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dp_q <= '0;
    else     dp_q <= dp_d;
  end

  // Response sequencer: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OKAY;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // Response sequencer: next state; ERR2 already accepts a new address phase
  always_comb begin
    state_d     = state_q;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
    case (state_q)
      ERR1:    state_d = ERR2;
      default: state_d = ap_err_c ? ERR1 : OKAY;
    endcase
    if (state_d == ERR1) hreadyout_d = 1'b0;
    if (state_d != OKAY) hresp_d = HRESP_ERROR;
  end

  // Data-phase write strobes
  assign wr_ctrl_c   = dp_q.valid & dp_q.write & (dp_q.off == OFF_CTRL);
  assign wr_load_c   = dp_q.valid & dp_q.write & (dp_q.off == OFF_LOAD);
  assign wr_value_c  = dp_q.valid & dp_q.write & (dp_q.off == OFF_VALUE);
  assign wr_status_c = dp_q.valid & dp_q.write & (dp_q.off == OFF_STATUS);

`ifdef AHB_TIMER_PRESCALE_EN
  logic [PRE_W-1:0] prescale_q;
  logic             wr_prescale_c;

  assign wr_prescale_c = dp_q.valid & dp_q.write & (dp_q.off == OFF_PRESCALE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                prescale_q <= '0;
    else if (wr_prescale_c) prescale_q <= bus.hwdata[PRE_W-1:0];
  end

  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_en_q),
    .clr      (wr_prescale_c),
    .prescale (prescale_q),
    .tick_c   (tick_c)
  );
`else
  assign tick_c = 1'b1;
`endif

  // Counter, reload and IRQ; bus writes are applied last so they win
  always_comb begin
    ctrl_en_d      = ctrl_en_q;
    ctrl_irqen_d   = ctrl_irqen_q;
    ctrl_oneshot_d = ctrl_oneshot_q;
    load_d         = load_q;
    value_d        = value_q;
    irq_d          = irq_q;
    zero_evt_c     = ctrl_en_q & tick_c & (value_q == '0);
    if (ctrl_en_q & tick_c) begin
      if (value_q != '0)      value_d = value_q - CNT_W'(1);
      else if (!ctrl_oneshot_q) value_d = load_q;
    end
    if (zero_evt_c) begin
      irq_d = 1'b1;
      if (ctrl_oneshot_q) ctrl_en_d = 1'b0;
    end else if (wr_status_c & bus.hwdata[0]) begin
      irq_d = 1'b0;
    end
    if (wr_ctrl_c) {ctrl_oneshot_d, ctrl_irqen_d, ctrl_en_d} = bus.hwdata[2:0];
    if (wr_load_c)  load_d  = bus.hwdata[CNT_W-1:0];
    if (wr_value_c) value_d = bus.hwdata[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en_q      <= 1'b0;
      ctrl_irqen_q   <= 1'b0;
      ctrl_oneshot_q <= 1'b0;
      load_q         <= '0;
      value_q        <= '0;
      irq_q          <= 1'b0;
      timer_irq      <= 1'b0;
    end else begin
      ctrl_en_q      <= ctrl_en_d;
      ctrl_irqen_q   <= ctrl_irqen_d;
      ctrl_oneshot_q <= ctrl_oneshot_d;
      load_q         <= load_d;
      value_q        <= value_d;
      irq_q          <= irq_d;
      timer_irq      <= irq_d & ctrl_irqen_d;
    end
  end

  // Read data is live register contents during a read data phase, else 0
  always_comb begin
    rdata_c = '0;
    if (dp_q.valid & ~dp_q.write) begin
      case (dp_q.off)
        OFF_CTRL:     rdata_c = {29'b0, ctrl_oneshot_q, ctrl_irqen_q, ctrl_en_q};
        OFF_LOAD:     rdata_c = 32'(load_q);
        OFF_VALUE:    rdata_c = 32'(value_q);
        OFF_STATUS:   rdata_c = {31'b0, irq_q};
`ifdef AHB_TIMER_PRESCALE_EN
        OFF_PRESCALE: rdata_c = 32'(prescale_q);
`endif
        default:      rdata_c = '0;
      endcase
    end
  end

  assign bus.hrdata    = rdata_c;
  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;

  assign unused_c = ^{bus.haddr[31:5], bus.haddr[1:0], bus.htrans[0], bus.hwdata};

endmodule

// File: doc/ahb_timer.md
Name: ahb_timer

Overview:
AHB-Lite slave timer peripheral on bus-matrix output port MI2, alongside the instruction and data SRAM slaves on MI0/MI1.
- 32-bit down-counter with reload, one-shot or periodic mode, level interrupt output.
- Zero-wait-state register access; two-cycle ERROR response for illegal accesses.

Parameters:
- CNT_W, 32, counter/LOAD width; must be ≤ 32; unused HRDATA bits read 0.
- PRE_W, 8, prescaler width (used only with AHB_TIMER_PRESCALE_EN).

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous reset, active-high (asserted = 1)
HSEL  in  1  slave select from bus matrix
HREADY  in  1  HREADYMUX from bus matrix
HTRANS  in  2  transfer type
HSIZE  in  3  transfer size
HWRITE  in  1  write/read
HADDR  in  32  address; [4:2] decoded
HWDATA  in  32  write data (data phase)
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
HRDATA  out  32  read data (data phase)
TIMER_IRQ  out  1  interrupt = STATUS.IRQ & CTRL.IRQEN

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, TIMER_IRQ=0. All registers 0. FSM state = OKAY.
- Address phase is valid when HSEL & HREADY & HTRANS[1]. On a valid phase, register HADDR[4:2], HWRITE, HSIZE and a valid flag. IDLE/BUSY transfers give an OKAY response with no side effects.
- Register map:
  - 0x00 CTRL: [0] EN, [1] IRQEN, [2] ONESHOT.
  - 0x04 LOAD: reload value.
  - 0x08 VALUE: read returns the live count; write sets the count.
  - 0x0C STATUS: [0] IRQ; write 1 to clear.
  - 0x10 PRESCALE: see Optional Feature.
  - 0x14–0x1C unmapped.
- Write: performed at the end of the data phase, using HWDATA sampled that cycle. Write latency is 1 cycle after the address phase.
- Read: HRDATA is driven in the data phase from the registered offset. It reflects register contents at that cycle. It is 0 when there is no valid read data phase.
- Error conditions: unmapped offset, or HSIZE ≠ 3'b010.
  - The register is not touched.
  - FSM sequence: OKAY → ERR1 (HREADYOUT=0, HRESP=1) → ERR2 (HREADYOUT=1, HRESP=1) → OKAY.
  - No address phase is sampled in ERR1, because HREADY is low.
- Tick: 1 every cycle (no prescaler), or the prescaler pulse.
- Counting, when CTRL.EN & tick:
  - VALUE≠0: VALUE ← VALUE−1.
  - VALUE=0: STATUS.IRQ ← 1. Periodic mode: VALUE ← LOAD. One-shot mode: CTRL.EN ← 0, VALUE holds 0.
- Priority within one cycle:
  - Bus write to VALUE overrides both decrement and reload.
  - Hardware IRQ set overrides a W1C clear.
  - A bus write to CTRL overrides the one-shot EN auto-clear.
- LOAD=0 in periodic mode: event on every tick.
- EN 0→1 does not reload; counting starts from the current VALUE.
- Reset mid-transfer: asynchronous return to reset state. Any pending write is dropped and the FSM goes to OKAY.

Optional Feature:
Macro AHB_TIMER_PRESCALE_EN.
- Defined: PRESCALE register [PRE_W-1:0], reset 0. A prescaler counter produces a tick every PRESCALE+1 cycles while EN=1. The counter clears when EN=0 or when PRESCALE is written.
- Undefined: tick = 1 every cycle. Offset 0x10 is unmapped and gives an ERROR response.

Decomposition:
- Package ahb_timer_pkg:
  - register offset constants (CTRL/LOAD/VALUE/STATUS/PRESCALE);
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ);
  - HRESP codes (OKAY, ERROR);
  - HSIZE_WORD;
  - response FSM state enum (OKAY, ERR1, ERR2).
- Sub-module timer_prescaler: counter plus tick generation; instantiated only under AHB_TIMER_PRESCALE_EN.

Test Plan:
- Periodic: write LOAD=3, VALUE=3, CTRL=0x3.
  - TIMER_IRQ rises exactly 4 ticks after EN; VALUE reloads to 3.
  - W1C STATUS=1 drops TIMER_IRQ the cycle after the data phase.
- One-shot: write VALUE=2, CTRL=0x7.
  - IRQ set after 3 ticks; CTRL reads 0x6; VALUE stays 0 for 20 cycles.
- Errors: read at 0x18, and a byte write (HSIZE=0) to 0x04.
  - Each gives HREADYOUT 0 then 1 with HRESP=1 on both cycles.
  - LOAD is unchanged afterwards.
- Back-to-back: pipelined write LOAD=0xA5A5A5A5 followed immediately by a read of LOAD.
  - The read returns 0xA5A5A5A5 with zero wait states.
- Collisions: a VALUE write coinciding with the zero event makes VALUE equal the written value. A STATUS W1C coinciding with the event leaves IRQ=1.
- Prescaler (macro defined): PRESCALE=4, LOAD=VALUE=1, CTRL=0x1 → STATUS.IRQ set every 10 HCLK cycles.
- Reset asserted during ERR1 → HREADYOUT=1 and HRESP=0 immediately.
